// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered RV32 decode/issue stage feeding the single-cycle ALU.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + instr/rs1_data/rs2_data upstream;
// flush drops held and incoming ops; out_valid/out_ready + alu_a/alu_b/alu_control/rd/
// reg_write/branch/illegal downstream; illegal_count saturates on accepted illegal ops.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_control,
  output logic [4:0]       rd,
  output logic             reg_write,
  output logic             branch,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      ctrl;
    logic [4:0]      rd;
    logic            reg_write;
    logic            branch;
    logic            illegal;
  } issue_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // rs1/rs2 fields are resolved by the register file before this stage
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  logic [XLEN-1:0] i_imm;
  logic [XLEN-1:0] s_imm;

  assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(XLEN-12){instr[31]}},
                  instr[31:25], instr[11:7]};

  // funct3 -> ALU code shared by R-type and I-type arithmetic
  logic       f3_ok;
  logic [2:0] f3_ctrl;

  always_comb begin
    f3_ok   = 1'b1;
    f3_ctrl = ALU_ADD;
    unique case (funct3)
      F3_ADD:  f3_ctrl = ALU_ADD;
      F3_AND:  f3_ctrl = ALU_AND;
      F3_OR:   f3_ctrl = ALU_OR;
      F3_SLT:  f3_ctrl = ALU_SLT;
      default: f3_ok   = 1'b0;
    endcase
  end

  logic is_r_base;
  logic is_r_sub;
  logic is_r;
  logic is_i;
  logic is_ld;
  logic is_st;
  logic is_br;

  assign is_r_base = (funct7 == F7_BASE) && f3_ok;
  assign is_r_sub  = (funct7 == F7_ALT)
                  && (funct3 == F3_ADD);
  assign is_r  = (opcode == OP_R)
              && (is_r_base || is_r_sub);
  assign is_i  = (opcode == OP_I) && f3_ok;
  assign is_ld = (opcode == OP_LD)
              && (funct3 == F3_W);
  assign is_st = (opcode == OP_ST)
              && (funct3 == F3_W);
  assign is_br = (opcode == OP_BR)
              && (funct3 == F3_BEQ);

  issue_t dec;

  always_comb begin
    dec    = '0;
    dec.a  = rs1_data;
    dec.rd = instr[11:7];
    unique case (1'b1)
      is_r: begin
        dec.b         = rs2_data;
        dec.ctrl      = is_r_sub ? ALU_SUB : f3_ctrl;
        dec.reg_write = 1'b1;
      end
      is_i: begin
        dec.b         = i_imm;
        dec.ctrl      = f3_ctrl;
        dec.reg_write = 1'b1;
      end
      is_ld: begin
        dec.b         = i_imm;
        dec.ctrl      = ALU_ADD;
        dec.reg_write = 1'b1;
      end
      is_st: begin
        dec.b    = s_imm;
        dec.ctrl = ALU_ADD;
      end
      is_br: begin
        dec.b      = rs2_data;
        dec.ctrl   = ALU_SUB;
        dec.branch = 1'b1;
      end
      default: begin
        // unsupported ops still issue, with zeroed operands
        dec.a       = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  issue_t q;
  logic   accept;
  logic   cnt_full;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cnt_full = &illegal_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      q             <= '0;
      out_valid     <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      q         <= dec;
      out_valid <= 1'b1;
      if (dec.illegal && !cnt_full)
        illegal_count <= illegal_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_a       = q.a;
  assign alu_b       = q.b;
  assign alu_control = q.ctrl;
  assign rd          = q.rd;
  assign reg_write   = q.reg_write;
  assign branch      = q.branch;
  assign illegal     = q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage that produces the operation stream consumed by the single-cycle ALU: alu_a, alu_b and the 3-bit alu_control code.
- Decodes a 32-bit RV32 instruction plus register-file read data into ALU operands and control.
- Holds the result in one pipeline register with a valid/ready handshake on both sides.
- Sits between register-file read and the execute stage.

Parameters:
- XLEN, 32, operand/data width.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept
- instr  input  32  instruction word
- rs1_data  input  XLEN  register rs1 value
- rs2_data  input  XLEN  register rs2 value
- flush  input  1  discard held/incoming op
- out_valid  output  1  issued op valid
- out_ready  input  1  execute stage accepts
- alu_a  output  XLEN  ALU operand a
- alu_b  output  XLEN  ALU operand b
- alu_control  output  3  000 add, 001 sub, 111 and, 011 or, 101 slt
- rd  output  5  destination register
- reg_write  output  1  writeback enable
- branch  output  1  beq: execute tests ALU zero
- illegal  output  1  unsupported encoding
- illegal_count  output  CNT_W  saturating count of issued illegal ops

Behaviour:
- Reset: all outputs 0, including out_valid, payload and illegal_count. Reset applies mid-transfer; any held op is lost.
- in_ready = !flush && (!out_valid || out_ready). This is combinational.
- Accept: in_valid && in_ready at a rising edge. The payload is registered and out_valid=1 on the next cycle, giving 1-cycle latency.
- Hold: while out_valid && !out_ready, every output stays stable. Back-to-back accepts sustain 1 op/cycle when out_ready=1.
- Flush: the next cycle has out_valid=0 and a dropped input. Flush overrides a simultaneous accept. Payload registers may keep stale values but must be ignored.
- Decode (opcode, funct3, funct7). a=rs1_data unless stated.
  - 0110011 R-type, b=rs2_data, reg_write=1:
    - 000/0000000 gives 000.
    - 000/0100000 gives 001.
    - 111/0000000 gives 111.
    - 110/0000000 gives 011.
    - 010/0000000 gives 101.
  - 0010011 I-type, b=sext(instr[31:20]), reg_write=1: funct3 000 gives 000, 111 gives 111, 110 gives 011, 010 gives 101.
  - 0000011, funct3 010 (lw): 000, b=sext I-imm, reg_write=1.
  - 0100011, funct3 010 (sw): 000, b=sext({instr[31:25],instr[11:7]}), reg_write=0.
  - 1100011, funct3 000 (beq): 001, b=rs2_data, branch=1, reg_write=0.
  - Any other encoding: illegal=1, alu_control=000, a=b=0, reg_write=0, branch=0. The op is still issued, with out_valid=1.
- rd=instr[11:7] for all ops. It is meaningful only when reg_write=1.
- illegal_count increments by 1 on each accepted illegal op. It saturates at 2^CNT_W-1 and never wraps. A flushed or un-accepted op does not count.
- Sign extension replicates instr[31] to XLEN bits.

Test Plan:
- add: instr=0x002081B3, rs1=5, rs2=7, in_valid=1, out_ready=1. Next cycle requires out_valid=1, alu_control=000, a=5, b=7, rd=3, reg_write=1, illegal=0.
- sub and addi:
  - 0x402081B3 must give alu_control=001.
  - 0xFFF00293 with rs1=0 must give alu_control=000, a=0, b=0xFFFFFFFF, rd=5.
- beq: 0x00208463, rs1=9, rs2=9. Requires alu_control=001, a=b=9, branch=1, reg_write=0.
- Backpressure: issue op A, then hold out_ready=0 for 3 cycles with op B valid. Requires in_ready=0 and A stable all 3 cycles. Raise out_ready: A retires, B appears on the following cycle with no loss or duplication.
- Illegal and counter:
  - 0xFFFFFFFF must give illegal=1, alu_control=000, illegal_count 0 to 1.
  - 300 consecutive illegal ops must saturate illegal_count at 255.
- Flush and reset:
  - flush=1 with in_valid=1 must give in_ready=0, then out_valid=0 next cycle with illegal_count unchanged.
  - reset=1 while out_valid=1 and out_ready=0 must clear all outputs to 0 on the next edge.
